// File: rtl/if_else_pkg.sv
// Shared constants and condition evaluation for the if/else pipeline selector.
package if_else_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    MODE_BIT  = 1'b0,
    MODE_MASK = 1'b1
  } mode_e;

  // MODE_BIT picks a single bit; MODE_MASK compares the masked word against val.
  function automatic logic cond_eval(input mode_e                mode,
                                     input int unsigned          bit_idx,
                                     input logic [MAX_W-1:0]     mask,
                                     input logic [MAX_W-1:0]     val,
                                     input logic [MAX_W-1:0]     data);
    logic [MAX_W-1:0] sh;
    sh = data >> bit_idx;
    if (mode == MODE_BIT) begin
      return sh[0];
    end
    return ((data & mask) == val);
  endfunction

endpackage

// File: rtl/if_else_pipe_select_delay.sv
// Enable-gated register chain; DEPTH=0 is a plain wire.
module branch_delay_line #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{clk_i, rst_i, en_i};
    assign q_o = d_i;
  end else begin : g_chain
    logic [W-1:0] stage_q [DEPTH];

    // Shift the chain forward whenever the pipeline advances.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else if (en_i) begin
        stage_q[0] <= d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/if_else_pipe_select.sv
// Pipelined multi-channel if/else selector with valid/ready and if-count.
module if_else_pipe_select
  import if_else_pkg::*;
#(
  parameter int unsigned W         = 32,
  parameter int unsigned CH        = 4,
  parameter int unsigned IF_LAT    = 2,
  parameter int unsigned ELSE_LAT  = 1,
  parameter int unsigned MODE      = 0,
  parameter int unsigned COND_BIT  = 0,
  parameter logic [W-1:0] COND_MASK = '1,
  parameter logic [W-1:0] COND_VAL  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    input_bit,
  input  logic [CH*W-1:0] array_ref_wire,
  input  logic [CH*W-1:0] array_ref_m_wire,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*W-1:0] segment_combine,
  output logic            cond_out,
  output logic [CNT_W-1:0] if_count,
  input  logic            count_clear
);

  localparam int unsigned L     = ((IF_LAT > ELSE_LAT) ? IF_LAT : ELSE_LAT) + 1;
  localparam int unsigned DEPTH = L - 1;
  localparam mode_e       MODE_E = (MODE == 1) ? MODE_MASK : MODE_BIT;

  logic            adv;
  logic            accept;
  logic            cond_in;
  logic [1:0]      ctl_q;
  logic [CH*W-1:0] if_q;
  logic [CH*W-1:0] else_q;

  logic            out_valid_q, out_valid_d;
  logic            cond_q, cond_d;
  logic [CH*W-1:0] seg_q, seg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign cond_in  = cond_eval(MODE_E, COND_BIT, MAX_W'(COND_MASK),
                              MAX_W'(COND_VAL), MAX_W'(input_bit));

  // Both operands get padded to the same depth so the longer branch sets latency.
  branch_delay_line #(.W(CH*W), .DEPTH(DEPTH)) u_if_dl (
    .clk_i(clk), .rst_i(reset), .en_i(adv), .d_i(array_ref_wire), .q_o(if_q)
  );

  branch_delay_line #(.W(CH*W), .DEPTH(DEPTH)) u_else_dl (
    .clk_i(clk), .rst_i(reset), .en_i(adv), .d_i(array_ref_m_wire), .q_o(else_q)
  );

  // Valid and condition travel together alongside their beat.
  branch_delay_line #(.W(2), .DEPTH(DEPTH)) u_ctl_dl (
    .clk_i(clk), .rst_i(reset), .en_i(adv), .d_i({accept, cond_in}), .q_o(ctl_q)
  );

  // Output-stage next state: load on advance, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    cond_d      = cond_q;
    seg_d       = seg_q;
    if (adv) begin
      out_valid_d = ctl_q[1];
      cond_d      = ctl_q[0];
      for (int unsigned c = 0; c < CH; c++) begin
        seg_d[c*W +: W] = ctl_q[0] ? if_q[c*W +: W] : else_q[c*W +: W];
      end
    end
  end

  // If-count next state: clear wins over a coincident increment; saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (count_clear) begin
      cnt_d = '0;
    end else if (out_valid_q && out_ready && cond_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output stage and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      cond_q      <= 1'b0;
      seg_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      cond_q      <= cond_d;
      seg_q       <= seg_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign cond_out        = cond_q;
  assign segment_combine = seg_q;
  assign if_count        = cnt_q;

endmodule
